// File: rtl/binary_frame_buffer_if.sv
// Pixel-write / scan-out bundle between the threshold stage, the frame buffer and the display port.
interface binary_frame_buffer_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
);
  logic [WIDTH_BITS-1:0]             iCol;
  logic [HEIGHT_BITS-1:0]            iRow;
  logic                              iData;
  logic                              iWren;
  logic                              iStart;
  logic                              oBusy;
  logic                              oFrameDone;
  logic                              oOverrun;
  logic [WIDTH_BITS+HEIGHT_BITS:0]   oWhiteCount;
  logic [WIDTH_BITS-1:0]             oX;
  logic [HEIGHT_BITS-1:0]            oY;
  logic [2:0]                        oR;
  logic [2:0]                        oG;
  logic [2:0]                        oB;

  modport master (
    output iCol, iRow, iData, iWren, iStart,
    input  oBusy, oFrameDone, oOverrun, oWhiteCount, oX, oY, oR, oG, oB
  );

  modport slave (
    input  iCol, iRow, iData, iWren, iStart,
    output oBusy, oFrameDone, oOverrun, oWhiteCount, oX, oY, oR, oG, oB
  );
endinterface

// File: rtl/binary_frame_buffer.sv
// One-bit frame memory: captures thresholded pixels, clears itself on reset/iStart,
// and continuously rasters its contents out as X/Y/RGB.
module binary_frame_buffer #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                  clock,
  input  logic                  not_reset,
  binary_frame_buffer_if.slave  bus
);
  localparam int AW    = WIDTH_BITS + HEIGHT_BITS;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] WHITE_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_clr_addr;
  logic [AW-1:0]   w_clr_addr_next;
  logic            w_accept;
  logic            w_overrun_set;
  logic            w_flags_clr;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic            w_mem_din;

  logic            r_mem [DEPTH];
  logic            r_pix;
  logic [AW-1:0]   r_raster;
  logic [AW-1:0]   r_scan_addr;
  logic            r_frame_done;
  logic            r_overrun;
  logic [AW:0]     r_white;

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_accept        = 1'b0;
    w_overrun_set   = 1'b0;
    w_flags_clr     = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_addr      = r_clr_addr;
    w_mem_din       = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we = 1'b1;
        if (bus.iStart) begin
          w_clr_addr_next = '0;
          w_flags_clr     = 1'b1;
        end else begin
          w_overrun_set   = bus.iWren;
          w_clr_addr_next = r_clr_addr + 1'b1;
          if (r_clr_addr == '1) w_state_next = S_READY;
        end
      end
      S_READY: begin
        // A write colliding with iStart is dropped silently: the frame it belonged to is abandoned.
        if (bus.iStart) begin
          w_state_next    = S_CLEAR;
          w_clr_addr_next = '0;
          w_flags_clr     = 1'b1;
        end else if (bus.iWren) begin
          w_accept   = 1'b1;
          w_mem_we   = 1'b1;
          w_mem_addr = {bus.iRow, bus.iCol};
          w_mem_din  = bus.iData;
        end
      end
      default: w_state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_white      <= '0;
    end else if (w_flags_clr) begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_white      <= '0;
    end else begin
      if (w_overrun_set) r_overrun <= 1'b1;
      if (w_accept && bus.iCol == '1 && bus.iRow == '1) r_frame_done <= 1'b1;
      if (w_accept && bus.iData && r_white != WHITE_MAX) r_white <= r_white + 1'b1;
    end
  end

  // Memory has no reset; contents are defined only by the clear sweep.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  end

  // Scan-out: address register and read data both lag the raster counter by one cycle.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_raster    <= '0;
      r_scan_addr <= '0;
      r_pix       <= 1'b0;
    end else begin
      r_raster    <= r_raster + 1'b1;
      r_scan_addr <= r_raster;
      r_pix       <= r_mem[r_raster];
    end
  end

  assign bus.oBusy       = (r_state == S_CLEAR);
  assign bus.oFrameDone  = r_frame_done;
  assign bus.oOverrun    = r_overrun;
  assign bus.oWhiteCount = r_white;
  assign bus.oX          = r_scan_addr[WIDTH_BITS-1:0];
  assign bus.oY          = r_scan_addr[AW-1:WIDTH_BITS];
  assign bus.oR          = {3{r_pix}};
  assign bus.oG          = {3{r_pix}};
  assign bus.oB          = {3{r_pix}};
endmodule

// File: tb/tb_binary_frame_buffer.sv
// Directed bench for binary_frame_buffer on a 32x32 frame so every clear and scan stays short.
module tb_binary_frame_buffer;
  localparam int W = 5;
  localparam int H = 5;
  localparam int N = 2 ** (W + H);

  logic clock = 1'b0;
  logic not_reset = 1'b0;
  int   asserts = 0;
  int   fails = 0;
  bit   exp_mem [N];

  always #5 clock = ~clock;

  binary_frame_buffer_if #(.WIDTH_BITS(W), .HEIGHT_BITS(H)) bus ();

  binary_frame_buffer #(.WIDTH_BITS(W), .HEIGHT_BITS(H)) dut (
    .clock     (clock),
    .not_reset (not_reset),
    .bus       (bus)
  );

  typedef struct {
    int col;
    int row;
    bit data;
    bit wren;
    int exp_white;
    bit exp_done;
    bit exp_ov;
    bit exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clock); #1;
      n++;
      if (!bus.oBusy) return;
    end
    n = -1;
  endtask

  task automatic scan_check(input string name);
    int errs = 0;
    int prev = -1;
    int idx;
    for (int i = 0; i < N; i++) begin
      @(posedge clock); #1;
      idx = int'(bus.oY) * (2 ** W) + int'(bus.oX);
      if (prev >= 0 && idx != (prev + 1) % N) errs++;
      prev = idx;
      if (bus.oR !== {3{exp_mem[idx]}} || bus.oG !== {3{exp_mem[idx]}} ||
          bus.oB !== {3{exp_mem[idx]}}) errs++;
    end
    check(name, errs, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_mem[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int n;
    int m;

    vecs[0] = '{5,  3,  1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{31, 31, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{7,  7,  1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{7,  7,  1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{7,  7,  1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{7,  7,  1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{31, 31, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{3,  5,  1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0};

    bus.iCol = '0; bus.iRow = '0; bus.iData = 1'b0; bus.iWren = 1'b0; bus.iStart = 1'b0;
    clear_model();

    // Reset values and clear after reset
    #1;
    check("rst_busy", bus.oBusy, 1);
    check("rst_done", bus.oFrameDone, 0);
    check("rst_overrun", bus.oOverrun, 0);
    check("rst_white", bus.oWhiteCount, 0);
    check("rst_x", bus.oX, 0);
    check("rst_y", bus.oY, 0);
    check("rst_r", bus.oR, 0);
    #11 not_reset = 1'b1;
    @(posedge clock); #1;
    check("scan0_x", bus.oX, 0);
    check("scan0_y", bus.oY, 0);
    @(posedge clock); #1;
    check("scan1_x", bus.oX, 1);
    @(posedge clock); #1;
    check("scan2_x", bus.oX, 2);
    check("busy_during_clear", bus.oBusy, 1);
    wait_clear(m);
    check("clear_len_reset", 3 + m, N);
    check("white_after_clear", bus.oWhiteCount, 0);
    scan_check("scan_all_zero_after_reset");

    // Table-driven writes in READY
    for (int i = 0; i < 8; i++) begin
      bus.iCol  = W'(vecs[i].col);
      bus.iRow  = H'(vecs[i].row);
      bus.iData = vecs[i].data;
      bus.iWren = vecs[i].wren;
      @(posedge clock); #1;
      if (vecs[i].wren) exp_mem[vecs[i].row * (2 ** W) + vecs[i].col] = vecs[i].data;
      check($sformatf("vec%0d_white", i), bus.oWhiteCount, vecs[i].exp_white);
      check($sformatf("vec%0d_done", i), bus.oFrameDone, vecs[i].exp_done);
      check($sformatf("vec%0d_overrun", i), bus.oOverrun, vecs[i].exp_ov);
      check($sformatf("vec%0d_busy", i), bus.oBusy, vecs[i].exp_busy);
    end
    bus.iWren = 1'b0;
    bus.iData = 1'b0;
    check("model_5_3", exp_mem[3 * 32 + 5], 1);
    scan_check("scan_pattern");

    // iStart with a colliding write, then writes during clear
    bus.iStart = 1'b1; bus.iWren = 1'b1; bus.iData = 1'b1;
    bus.iCol = W'(10); bus.iRow = H'(10);
    @(posedge clock); #1;
    bus.iStart = 1'b0; bus.iWren = 1'b0;
    check("start_busy", bus.oBusy, 1);
    check("start_overrun", bus.oOverrun, 0);
    check("start_white", bus.oWhiteCount, 0);
    check("start_done", bus.oFrameDone, 0);
    clear_model();
    bus.iWren = 1'b1; bus.iCol = W'(12); bus.iRow = H'(12);
    @(posedge clock); #1;
    bus.iWren = 1'b0;
    n = 1;
    check("overrun_set", bus.oOverrun, 1);
    wait_clear(m);
    check("clear_len_start", (m < 0) ? -1 : n + m, N);
    check("overrun_sticky", bus.oOverrun, 1);
    check("white_after_overrun", bus.oWhiteCount, 0);
    scan_check("scan_zero_after_start");
    check("overrun_still_sticky", bus.oOverrun, 1);

    // Reset asserted at clear address 1000
    bus.iStart = 1'b1;
    @(posedge clock); #1;
    bus.iStart = 1'b0;
    bus.iWren = 1'b1; bus.iData = 1'b1;
    @(posedge clock); #1;
    bus.iWren = 1'b0;
    check("midclr_overrun_before", bus.oOverrun, 1);
    repeat (999) @(posedge clock);
    #1;
    not_reset = 1'b0;
    #1;
    check("midrst_busy", bus.oBusy, 1);
    check("midrst_overrun", bus.oOverrun, 0);
    check("midrst_done", bus.oFrameDone, 0);
    check("midrst_white", bus.oWhiteCount, 0);
    check("midrst_x", bus.oX, 0);
    check("midrst_y", bus.oY, 0);
    check("midrst_r", bus.oR, 0);
    #1 not_reset = 1'b1;
    wait_clear(m);
    check("clear_len_midrst", m, N);
    scan_check("scan_zero_after_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/binary_frame_buffer.md
# binary_frame_buffer

Downstream stage of the box-filter/threshold pipeline. Captures the binary result stream (column, row, pixel, write-enable) into a 256×256 one-bit frame memory, then continuously scans it out as X/Y/RGB for the display port. Also reports a frame-complete flag, a count of white pixels written, and a sticky flag for writes dropped while the memory is being cleared. Replaces the direct wiring of filter results to the display outputs.

## Interface
- WIDTH_BITS, 8, column address width (frame width 2**WIDTH_BITS)
- HEIGHT_BITS, 8, row address width (frame height 2**HEIGHT_BITS)

- clock  in  1  system clock
- not_reset  in  1  asynchronous, active-low reset
- iCol  in  WIDTH_BITS  column of the incoming result pixel
- iRow  in  HEIGHT_BITS  row of the incoming result pixel
- iData  in  1  result pixel value (1 = white)
- iWren  in  1  write strobe for iCol/iRow/iData
- iStart  in  1  single-cycle request to clear the memory and begin a new frame
- oBusy  out  1  high while clearing
- oFrameDone  out  1  set when pixel (max col, max row) is written
- oOverrun  out  1  sticky: an iWren arrived while busy
- oWhiteCount  out  WIDTH_BITS+HEIGHT_BITS+1  number of accepted writes with iData=1
- oX  out  WIDTH_BITS  scan-out column
- oY  out  HEIGHT_BITS  scan-out row
- oR, oG, oB  out  3 each  {3{pixel}} at (oX, oY)

## Operation
- Memory: 2**(WIDTH_BITS+HEIGHT_BITS) × 1 bit. Address {row, col}. One write port and one synchronous read port. A read at an address written in the same cycle returns the old value.
- States:
  - CLEAR: a clear counter writes 0 to address k on the k-th edge. After the last address, go to READY. oBusy=1. iWren is ignored and sets oOverrun.
  - READY: an iWren writes iData at {iRow, iCol}. oBusy=0.
- Reset enters CLEAR with the clear counter at 0. Block RAM has no reset, so reset always clears the memory.
- iStart in READY:
  - go to CLEAR with the counter at 0;
  - clear oFrameDone, oOverrun and oWhiteCount;
  - a same-cycle iWren is dropped and does not set oOverrun.
- iStart in CLEAR restarts the clear counter at 0. Flags are cleared the same way.
- oWhiteCount increments on each accepted write with iData=1. It counts rewrites of the same pixel again. It saturates at 2**(WIDTH_BITS+HEIGHT_BITS).
- oFrameDone is set by an accepted write at col=all-ones, row=all-ones. It holds until iStart or reset.
- Scan-out:
  - a free-running raster counter (col fastest, wrapping to 0,0 after max,max) runs in every state and reads the memory;
  - oX/oY are the counter delayed one cycle, so they align with the read data;
  - oR/oG/oB = {3{read bit}}.
  - In CLEAR the scan shows partially cleared contents; this is acceptable.

## Timing
- Reset values: oBusy=1, oFrameDone=0, oOverrun=0, oWhiteCount=0, oX=0, oY=0, oR=oG=oB=0. Raster counter = 0. Clear counter = 0.
- Clear length is exactly 2**(WIDTH_BITS+HEIGHT_BITS) edges:
  - address 0 is written on the first edge after reset deassertion or after the iStart edge;
  - the last address is written on edge 65536 (default size);
  - state becomes READY and oBusy falls on that same edge;
  - the first write is accepted on the following edge.
- Write latency: a pixel written at edge n appears on the scan-out one cycle after its address is issued, if issued after edge n.
- Scan-out: after reset, (oX, oY) = (0,0) for the first edge, (1,0) for the next, and so on. Full period is 65536 cycles.
- oFrameDone, oOverrun and oWhiteCount update on the edge that accepts or rejects the write.
- Reset asserted mid-operation aborts everything immediately. Memory contents are undefined until the new clear completes.

## Test plan
- Clear after reset: release reset and hold iWren=0 → oBusy=1 for exactly 65536 edges, then 0. A full scan then shows all oR=0. oWhiteCount=0.
- Write/readback: write (col 5, row 3, 1) and (255, 255, 1) → the scan shows oR=3'b111 exactly at oX=5/oY=3 and oX=255/oY=255, 0 elsewhere. oWhiteCount=2. oFrameDone=1 after the second write.
- Overrun: iWren=1 during CLEAR → oOverrun=1 and stays 1. The pixel stays 0 after the clear completes.
- Saturation/rewrites: write (7, 7, 1) three times, then (7, 7, 0) → oWhiteCount=3 and pixel (7,7) reads 0.
- iStart collision: in READY, assert iStart and iWren (10, 10, 1) in the same cycle → write dropped, oOverrun=0, oWhiteCount=0, oFrameDone=0, oBusy=1 for 65536 edges.
- Reset mid-clear: assert not_reset=0 at clear address 1000 → outputs take their reset values at once. After release, the clear runs a full 65536 edges again.
